// File: rtl/comparator_pkg.sv
// ============================================================================
// comparator_pkg : shared types for the serial magnitude comparator
// Revision 1.0
// ============================================================================
`default_nettype none

package comparator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      EQ = 2'b00,
      LT = 2'b01,
      GT = 2'b10
   } dec_e;

   // Result flags packed as {a_e_b, a_l_b, a_g_b}.
   function automatic logic [2:0] dec_to_flags(input dec_e d);
      logic [2:0] f;
      f = 3'b000;
      case (d)
         EQ:      f = 3'b100;
         LT:      f = 3'b010;
         GT:      f = 3'b001;
         default: f = 3'b100;
      endcase
      return f;
   endfunction

endpackage

`default_nettype wire

// File: rtl/comparator.sv
// ============================================================================
// comparator : single-bit magnitude comparator cell
// Revision 1.0
// ============================================================================
`default_nettype none

module comparator (
   input  logic a_in,
   input  logic b_in,
   output logic eq_out,
   output logic lt_out,
   output logic gt_out
);

   assign eq_out = ~(a_in ^ b_in);
   assign lt_out = ~a_in & b_in;
   assign gt_out = a_in & ~b_in;

endmodule

`default_nettype wire

// File: rtl/serial_comparator.sv
// ============================================================================
// serial_comparator : MSB-first bit-serial compare of two WIDTH-bit operands
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_comparator
   import comparator_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_in,
   input  logic bit_valid_in,
   input  logic a_bit_in,
   input  logic b_bit_in,
   output logic busy,
   output logic done,
   output logic a_e_b,
   output logic a_l_b,
   output logic a_g_b
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

   state_e           state_q, state_d;
   dec_e             dec_q, dec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       flags_q, flags_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic cell_eq, cell_lt, cell_gt;
   logic bit_accept;

   comparator u_cell (
      .a_in   (a_bit_in),
      .b_in   (b_bit_in),
      .eq_out (cell_eq),
      .lt_out (cell_lt),
      .gt_out (cell_gt)
   );

   assign bit_accept = (state_q == SHIFT) && bit_valid_in;

   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      cnt_d   = cnt_q;
      flags_d = flags_q;

      case (state_q)
         IDLE: begin
            if (start_in) begin
               state_d = SHIFT;
               cnt_d   = '0;
               dec_d   = EQ;
               flags_d = 3'b000;
            end
         end

         SHIFT: begin
            if (bit_accept) begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
               // Only the first differing bit pair decides; later bits are ignored.
               if (dec_q == EQ && !cell_eq) begin
                  dec_d = cell_gt ? GT : (cell_lt ? LT : EQ);
               end
               if (cnt_q == CNT_LAST) begin
                  state_d = DONE;
                  flags_d = dec_to_flags(dec_d);
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dec_q   <= EQ;
         cnt_q   <= '0;
         flags_q <= 3'b000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dec_q   <= dec_d;
         cnt_q   <= cnt_d;
         flags_q <= flags_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign a_e_b = flags_q[2];
   assign a_l_b = flags_q[1];
   assign a_g_b = flags_q[0];

endmodule

`default_nettype wire

// File: tb/tb_serial_comparator.sv
// ============================================================================
// tb_serial_comparator : randomized self-checking bench for serial_comparator
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_comparator;

   localparam int WIDTH = 8;

   logic clk          = 1'b0;
   logic rst_n        = 1'b0;
   logic start_in     = 1'b0;
   logic bit_valid_in = 1'b0;
   logic a_bit_in     = 1'b0;
   logic b_bit_in     = 1'b0;
   logic busy, done, a_e_b, a_l_b, a_g_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_comparator #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_in     (start_in),
      .bit_valid_in (bit_valid_in),
      .a_bit_in     (a_bit_in),
      .b_bit_in     (b_bit_in),
      .busy         (busy),
      .done         (done),
      .a_e_b        (a_e_b),
      .a_l_b        (a_l_b),
      .a_g_b        (a_g_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: {eq, lt, gt} from plain unsigned comparison of whole operands.
   function automatic logic [2:0] golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (a == b) return 3'b100;
      if (a < b)  return 3'b010;
      return 3'b001;
   endfunction

   function automatic logic [2:0] flags();
      return {a_e_b, a_l_b, a_g_b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic a, input logic b, input int gap, input bit stray_start);
      for (int g = 0; g < gap; g++) begin
         bit_valid_in = 1'b0;
         a_bit_in     = 1'($urandom);
         b_bit_in     = 1'($urandom);
         start_in     = stray_start;
         tick();
         check("stall_busy", busy, 1);
         check("stall_done", done, 0);
      end
      bit_valid_in = 1'b1;
      a_bit_in     = a;
      b_bit_in     = b;
      start_in     = stray_start;
      tick();
      bit_valid_in = 1'b0;
      start_in     = 1'b0;
   endtask

   task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input int gap, input bit rand_gap, input bit misuse);
      logic [2:0] exp;
      int         g;
      exp = golden(a, b);
      if (misuse) begin
         bit_valid_in = 1'b1;
         a_bit_in     = 1'($urandom);
         b_bit_in     = 1'($urandom);
         tick();
         check("idle_valid_busy", busy, 0);
         check("idle_valid_done", done, 0);
      end
      start_in     = 1'b1;
      bit_valid_in = misuse;
      a_bit_in     = 1'b1;
      b_bit_in     = 1'b0;
      tick();
      start_in     = 1'b0;
      bit_valid_in = 1'b0;
      check("start_busy", busy, 1);
      check("start_flags", flags(), 3'b000);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         g = rand_gap ? int'($urandom_range(0, gap)) : gap;
         send_bit(a[i], b[i], g, misuse);
         if (i > 0) begin
            check("early_done", done, 0);
            check("shift_busy", busy, 1);
         end
      end
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_flags", flags(), exp);
      start_in = misuse;
      tick();
      start_in = 1'b0;
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("hold_flags", flags(), exp);
      tick();
      check("hold_flags2", flags(), exp);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;

      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_flags", flags(), 3'b000);
      #20;
      rst_n = 1'b1;
      tick();

      run(8'hA5, 8'hA5, 0, 1'b0, 1'b0);
      run(8'h80, 8'h7F, 0, 1'b0, 1'b0);
      run(8'h3C, 8'h3D, 0, 1'b0, 1'b0);
      run(8'h12, 8'h34, 2, 1'b0, 1'b0);
      run(8'hC3, 8'hC3, 1, 1'b0, 1'b1);
      run(8'h5A, 8'h59, 1, 1'b0, 1'b1);

      // Async reset with flags held in IDLE.
      run(8'h80, 8'h7F, 0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_idle_flags", flags(), 3'b000);
      rst_n = 1'b1;
      tick();

      // Async reset mid-SHIFT after 3 bits, then orphan bits must not complete.
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 0, 1'b0);
      check("mid_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_flags", flags(), 3'b000);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < WIDTH; i++) begin
         send_bit(1'($urandom), 1'($urandom), 0, 1'b0);
         check("orphan_done", done, 0);
         check("orphan_busy", busy, 0);
      end
      tick();
      check("orphan_done_late", done, 0);

      for (int n = 0; n < 100; n++) begin
         ra = WIDTH'($urandom);
         rb = (n % 5 == 0) ? ra : WIDTH'($urandom);
         run(ra, rb, 2, 1'b1, (n % 4) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
